alu_result_decoder: RTL and testbench
=====================================

// Module: alu_result_decoder
// PURPOSE
//  Host-side companion to the registered 4-bit ALU. Tracks each operation issued to the ALU and aligns
//  it with the ALU's 1-cycle-late result/flags. Unpacks the result per opcode (DIV split, ENC decrypt,
//  flag masking) and queues decoded records in a FIFO with a valid/ready output handshake.
//  Sits between the ALU outputs (uo_out, uio_out[7:6]) and the consumer.
// PARAMETERS
//  DEPTH    4      decoded-record FIFO entries (power of 2, >=2)
//  ENC_KEY  8'hAB  XOR key used by ALU ENC op; decrypt = result ^ ENC_KEY
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   reset, asynchronous, active-low
//  issue_valid   in   1   operation presented to ALU this cycle
//  issue_ready   out  1   decoder can accept an issue (credit available)
//  issue_opcode  in   4   opcode driven to ALU (0=ADD..8=ENC, 9-15 illegal)
//  issue_a       in   4   operand a driven to ALU
//  issue_b       in   4   operand b driven to ALU
//  alu_result    in   8   ALU registered result
//  alu_carry     in   1   ALU carry_out
//  alu_overflow  in   1   ALU overflow
//  out_valid     out  1   decoded record at FIFO head
//  out_ready     in   1   consumer accepts head
//  out_opcode    out  4   opcode of record
//  out_data      out  8   primary decoded value
//  out_aux       out  4   secondary value (DIV remainder, else 0)
//  out_carry     out  1   carry (ADD/SUB only, else 0)
//  out_overflow  out  1   overflow (ADD/SUB only, else 0)
//  out_illegal   out  1   opcode 9-15
//  out_mismatch  out  1   self-check failure (ALU_DEC_CHECK_EN)
//  err_sticky    out  1   sticky OR of pushed mismatches (ALU_DEC_CHECK_EN)
//  err_clear     in   1   clears err_sticky (sync)
//  level         out  $clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0 except issue_ready=1; FIFO empty, level=0, in-flight stage empty, err_sticky=0.
//  Issue accepted when issue_valid & issue_ready; opcode/a/b captured into 1-entry in-flight stage.
//  Cycle N+1: stage valid -> sample alu_*, decode, push FIFO. Latency issue -> out_valid = 2 cycles.
//  issue_ready = (level + stage_valid) < DEPTH (registered terms only; a pop this cycle gives no credit).
//  FIFO never overflows by construction; push and pop in same cycle both take effect, level unchanged.
//  Pop when out_valid & out_ready; outputs show head combinationally from FIFO storage; out_* hold when stalled.
//  Decode (r=alu_result):
//   ADD/SUB: data={0,r[3:0]}, carry/overflow pass-through.
//   MUL: data=r.  DIV: data={0,r[3:0]} quotient, aux=r[7:4] remainder.
//   AND/OR/XOR/NOT: data={0,r[3:0]}.  ENC: data=r^ENC_KEY (recovers {a,b}).
//   9-15: data=0, illegal=1. Carry/overflow forced 0 for all non-ADD/SUB (ALU holds stale flags).
//  Back-to-back issues every cycle sustained while credit allows; stage reloads the cycle it drains.
//  err_clear and a same-cycle mismatch push: set wins. rst_n low mid-operation discards stage and FIFO.
// CONFIGURATION
//  ALU_DEC_CHECK_EN defined: stage compares against issued operands; mismatch if
//   ENC: r^ENC_KEY != {a,b}; DIV b!=0: q*b+r_rem != a or r_rem>=b; DIV b==0: r!=0;
//   ADD: r[3:0]!=(a+b)[3:0]; SUB: r[3:0]!=(a-b)[3:0]; illegal: r!=0.
//   Other opcodes never mismatch.
//  Undefined: out_mismatch and err_sticky tied 0, compare logic absent, err_clear ignored.
// STRUCTURE
//  Package alu_dec_pkg: opcode localparams (OP_ADD..OP_ENC), ENC_KEY default, decoded-record struct
//   {opcode, data, aux, carry, overflow, illegal, mismatch}.
//  One sub-module: alu_dec_fifo (parameterised sync FIFO, count, full/empty); decode logic stays in top.
// TESTING
//  ADD a=9,b=8; ALU returns 0x01,c=1,v=1 -> out_data=0x01, carry=1, overflow=1, 2 cycles after issue.
//  ENC a=3,b=5; ALU returns 0x9E -> out_data=0x35, carry=0, overflow=0 despite stale ALU flags=1.
//  DIV a=13,b=4; ALU 0x13 -> data=0x03, aux=1; DIV b=0, ALU 0x00 -> data=0, aux=0, mismatch=0.
//  out_ready=0, issue 6 ops back-to-back, DEPTH=4 -> 4 accepted, issue_ready=0, level=4; drain in order.
//  CHECK_EN: ENC a=3,b=5 with ALU 0x9F -> out_mismatch=1, err_sticky=1 until err_clear pulse.
//  Opcode 12 -> out_illegal=1, data=0; rst_n low with 3 queued -> out_valid=0, level=0, issue_ready=1.

Source files
------------

// File: rtl/alu_result_decoder_pkg.sv
// Shared opcode encodings, default ENC key and the decoded-record layout
// used by the ALU result decoder and its FIFO.
package alu_dec_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_ENC = 4'd8;

  localparam logic [7:0] ENC_KEY_DEFAULT = 8'hAB;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] data;
    logic [3:0] aux;
    logic       carry;
    logic       overflow;
    logic       illegal;
    logic       mismatch;
  } dec_rec_t;

endpackage

// File: rtl/alu_result_decoder_if.sv
// Issue, ALU-return and decoded-output bundle of the ALU result decoder.
// master = host/ALU side, slave = decoder.
interface alu_result_decoder_if;

  logic       issue_valid;
  logic       issue_ready;
  logic [3:0] issue_opcode;
  logic [3:0] issue_a;
  logic [3:0] issue_b;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_opcode;
  logic [7:0] out_data;
  logic [3:0] out_aux;
  logic       out_carry;
  logic       out_overflow;
  logic       out_illegal;
  logic       out_mismatch;

  modport master (
    output issue_valid, issue_opcode, issue_a, issue_b,
    output alu_result, alu_carry, alu_overflow, out_ready,
    input  issue_ready, out_valid, out_opcode, out_data, out_aux,
    input  out_carry, out_overflow, out_illegal, out_mismatch
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_a, issue_b,
    input  alu_result, alu_carry, alu_overflow, out_ready,
    output issue_ready, out_valid, out_opcode, out_data, out_aux,
    output out_carry, out_overflow, out_illegal, out_mismatch
  );

endinterface

// File: rtl/alu_result_decoder_fifo.sv
// Synchronous FIFO holding decoded records; head is visible combinationally on dout.
module alu_dec_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage is cleared too so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_result_decoder.sv
// Aligns issued ALU ops with the 1-cycle-late ALU result, decodes and queues records.
// Optional self-check of ALU results enabled by defining ALU_DEC_CHECK_EN.
module alu_result_decoder
  import alu_dec_pkg::*;
#(
  parameter int         DEPTH   = 4,
  parameter logic [7:0] ENC_KEY = ENC_KEY_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_result_decoder_if.slave        bus,
  input  logic                       err_clear,
  output logic                       err_sticky,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic           stage_valid;
  logic [3:0]     stage_op;
  logic [3:0]     stage_a;
  logic [3:0]     stage_b;
  logic           issue_fire;
  logic           issue_ready_int;
  logic [CNT_W:0] credit_used;
  logic [7:0]     res;
  logic           chk_mismatch;
  dec_rec_t       dec_rec;
  dec_rec_t       head_rec;
  logic           fifo_empty;
  logic           fifo_full_unused;
  logic           pop;

  assign res             = bus.alu_result;
  // Credit counts only registered occupancy, so a same-cycle pop never frees a slot early.
  assign credit_used     = {1'b0, level} + {{CNT_W{1'b0}}, stage_valid};
  assign issue_ready_int = credit_used < (CNT_W+1)'(DEPTH);
  assign issue_fire      = bus.issue_valid && issue_ready_int;
  assign bus.issue_ready = issue_ready_int;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_op    <= '0;
      stage_a     <= '0;
      stage_b     <= '0;
    end else begin
      stage_valid <= issue_fire;
      if (issue_fire) begin
        stage_op <= bus.issue_opcode;
        stage_a  <= bus.issue_a;
        stage_b  <= bus.issue_b;
      end
    end
  end

  // Flags are only meaningful for ADD/SUB; the ALU leaves stale flags for everything else.
  always_comb begin
    dec_rec          = '0;
    dec_rec.opcode   = stage_op;
    dec_rec.mismatch = chk_mismatch;
    case (stage_op)
      OP_ADD, OP_SUB: begin
        dec_rec.data     = {4'b0, res[3:0]};
        dec_rec.carry    = bus.alu_carry;
        dec_rec.overflow = bus.alu_overflow;
      end
      OP_MUL: dec_rec.data = res;
      OP_DIV: begin
        dec_rec.data = {4'b0, res[3:0]};
        dec_rec.aux  = res[7:4];
      end
      OP_AND, OP_OR, OP_XOR, OP_NOT: dec_rec.data = {4'b0, res[3:0]};
      OP_ENC: dec_rec.data = res ^ ENC_KEY;
      default: dec_rec.illegal = 1'b1;
    endcase
  end

`ifdef ALU_DEC_CHECK_EN
  logic [3:0] sum4;
  logic [3:0] diff4;
  logic [7:0] div_back;

  always_comb begin
    sum4         = stage_a + stage_b;
    diff4        = stage_a - stage_b;
    div_back     = 8'(res[3:0]) * 8'(stage_b) + 8'(res[7:4]);
    chk_mismatch = 1'b0;
    case (stage_op)
      OP_ADD: chk_mismatch = (res[3:0] != sum4);
      OP_SUB: chk_mismatch = (res[3:0] != diff4);
      OP_DIV: begin
        if (stage_b != 4'd0)
          chk_mismatch = (div_back != {4'b0, stage_a}) || (res[7:4] >= stage_b);
        else
          chk_mismatch = (res != 8'h00);
      end
      OP_ENC:  chk_mismatch = ((res ^ ENC_KEY) != {stage_a, stage_b});
      default: chk_mismatch = (stage_op > OP_ENC) && (res != 8'h00);
    endcase
  end

  // A mismatch being pushed beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_sticky <= 1'b0;
    else if (stage_valid && chk_mismatch) err_sticky <= 1'b1;
    else if (err_clear)                  err_sticky <= 1'b0;
  end
`else
  logic unused_chk;
  assign chk_mismatch = 1'b0;
  assign err_sticky   = 1'b0;
  assign unused_chk   = ^{err_clear, stage_a, stage_b};
`endif

  assign pop = bus.out_ready && !fifo_empty;

  alu_dec_fifo #(
    .WIDTH ($bits(dec_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_valid),
    .din   (dec_rec),
    .pop   (pop),
    .dout  (head_rec),
    .full  (fifo_full_unused),
    .empty (fifo_empty),
    .count (level)
  );

  assign bus.out_valid    = !fifo_empty;
  assign bus.out_opcode   = head_rec.opcode;
  assign bus.out_data     = head_rec.data;
  assign bus.out_aux      = head_rec.aux;
  assign bus.out_carry    = head_rec.carry;
  assign bus.out_overflow = head_rec.overflow;
  assign bus.out_illegal  = head_rec.illegal;
  assign bus.out_mismatch = head_rec.mismatch;

endmodule

// File: tb/tb_alu_result_decoder.sv
// Table-driven scoreboard bench for alu_result_decoder; follows ALU_DEC_CHECK_EN if defined.
module tb_alu_result_decoder;
  import alu_dec_pkg::*;

  localparam int DEPTH = 4;
`ifdef ALU_DEC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic [7:0] data;
    logic [3:0] aux;
    logic       carry;
    logic       ovf;
    logic       ill;
    logic       mis;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    logic [3:0] aux;
    logic       carry;
    logic       ovf;
    logic       ill;
    logic       mis;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clear = 1'b0;
  logic       err_sticky;
  logic [2:0] level;
  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[11];

  alu_result_decoder_if bus();

  alu_result_decoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .err_clear  (err_clear),
    .err_sticky (err_sticky),
    .level      (level)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(logic [3:0] op, logic [3:0] a, logic [3:0] b, logic [7:0] r,
                               logic c, logic v, logic [7:0] data, logic [3:0] aux,
                               logic carry, logic ovf, logic ill);
    vec_t t;
    t.op = op; t.a = a; t.b = b; t.r = r; t.c = c; t.v = v;
    t.data = data; t.aux = aux; t.carry = carry; t.ovf = ovf; t.ill = ill; t.mis = 1'b0;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  // One clock of stimulus: present cur as an issue and return the ALU result for prev.
  task automatic applyStimulus(input vec_t cur, input bit cur_v, input vec_t prev,
                               input bit prev_acc, output bit acc);
    exp_t e;
    bus.issue_valid  = cur_v;
    bus.issue_opcode = cur.op;
    bus.issue_a      = cur.a;
    bus.issue_b      = cur.b;
    if (prev_acc) begin
      bus.alu_result   = prev.r;
      bus.alu_carry    = prev.c;
      bus.alu_overflow = prev.v;
    end else begin
      bus.alu_result   = 8'hA5;
      bus.alu_carry    = 1'b1;
      bus.alu_overflow = 1'b1;
    end
    acc = cur_v && bus.issue_ready;
    if (acc) begin
      e.op = cur.op; e.data = cur.data; e.aux = cur.aux;
      e.carry = cur.carry; e.ovf = cur.ovf; e.ill = cur.ill; e.mis = cur.mis;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out: got opcode 0x%0h with empty scoreboard", bus.out_opcode);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("record",
          {12'b0, bus.out_opcode, bus.out_data, bus.out_aux, bus.out_carry,
           bus.out_overflow, bus.out_illegal, bus.out_mismatch},
          {12'b0, mon_e.op, mon_e.data, mon_e.aux, mon_e.carry, mon_e.ovf, mon_e.ill, mon_e.mis});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t prev;
    vec_t badv;
    bit   prev_acc;
    bit   acc;
    int   acc_cnt;

    vecs[0]  = mkv(OP_ADD, 4'd9,  4'd8, 8'h01, 1, 1, 8'h01, 4'd0, 1, 1, 0);
    vecs[1]  = mkv(OP_ENC, 4'd3,  4'd5, 8'h9E, 1, 1, 8'h35, 4'd0, 0, 0, 0);
    vecs[2]  = mkv(OP_DIV, 4'd13, 4'd4, 8'h13, 1, 0, 8'h03, 4'd1, 0, 0, 0);
    vecs[3]  = mkv(OP_DIV, 4'd7,  4'd0, 8'h00, 0, 1, 8'h00, 4'd0, 0, 0, 0);
    vecs[4]  = mkv(OP_SUB, 4'd5,  4'd7, 8'h0E, 1, 0, 8'h0E, 4'd0, 1, 0, 0);
    vecs[5]  = mkv(OP_MUL, 4'd7,  4'd9, 8'h3F, 1, 1, 8'h3F, 4'd0, 0, 0, 0);
    vecs[6]  = mkv(OP_AND, 4'hC,  4'hA, 8'h08, 1, 0, 8'h08, 4'd0, 0, 0, 0);
    vecs[7]  = mkv(OP_OR,  4'hC,  4'h3, 8'h0F, 0, 1, 8'h0F, 4'd0, 0, 0, 0);
    vecs[8]  = mkv(OP_XOR, 4'hF,  4'h5, 8'h0A, 1, 1, 8'h0A, 4'd0, 0, 0, 0);
    vecs[9]  = mkv(OP_NOT, 4'h3,  4'h0, 8'h0C, 1, 1, 8'h0C, 4'd0, 0, 0, 0);
    vecs[10] = mkv(4'd12,  4'h3,  4'h3, 8'h00, 1, 1, 8'h00, 4'd0, 0, 0, 1);
    badv     = mkv(OP_ENC, 4'd3,  4'd5, 8'h9F, 1, 1, 8'h34, 4'd0, 0, 0, 0);
    badv.mis = CHK;

    bus.issue_valid = 1'b0; bus.issue_opcode = '0; bus.issue_a = '0; bus.issue_b = '0;
    bus.alu_result = '0; bus.alu_carry = 1'b0; bus.alu_overflow = 1'b0; bus.out_ready = 1'b0;

    #12;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_issue_ready", bus.issue_ready, 1);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_err_sticky", err_sticky, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table pass, streamed back-to-back with the consumer always ready.
    bus.out_ready = 1'b1;
    prev_acc = 1'b0;
    prev = vecs[0];
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i], 1'b1, prev, prev_acc, acc);
      checkOutput("table_accept", acc, 1);
      if (i == 0) checkOutput("latency_1cyc_valid", bus.out_valid, 0);
      if (i == 1) checkOutput("latency_2cyc_valid", bus.out_valid, 1);
      prev = vecs[i];
      prev_acc = acc;
    end
    applyStimulus(vecs[0], 1'b0, prev, prev_acc, acc);
    waitDrain("table_drain");

    // Backpressure: six back-to-back issues with the consumer stalled.
    bus.out_ready = 1'b0;
    prev_acc = 1'b0;
    acc_cnt = 0;
    for (int c = 0; c < 7; c++) begin
      applyStimulus(vecs[c < 6 ? c : 0], c < 6, prev, prev_acc, acc);
      if (acc) acc_cnt++;
      prev = vecs[c < 6 ? c : 0];
      prev_acc = acc;
    end
    checkOutput("bp_accepted", acc_cnt, 4);
    checkOutput("bp_level", level, 4);
    checkOutput("bp_issue_ready", bus.issue_ready, 0);
    checkOutput("bp_hold_data_a", bus.out_data, sb[0].data);
    applyStimulus(vecs[0], 1'b0, prev, 1'b0, acc);
    checkOutput("bp_hold_data_b", bus.out_data, sb[0].data);
    checkOutput("bp_hold_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    waitDrain("bp_drain");
    checkOutput("bp_level_empty", level, 0);

    // Corrupted ENC result and sticky error flag.
    applyStimulus(badv, 1'b1, vecs[0], 1'b0, acc);
    prev_acc = acc;
    applyStimulus(vecs[0], 1'b0, badv, prev_acc, acc);
    waitDrain("mis_drain");
    checkOutput("err_sticky_set", err_sticky, CHK);
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    checkOutput("err_sticky_clr", err_sticky, 0);

    // Reset with three records queued.
    bus.out_ready = 1'b0;
    prev_acc = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(vecs[c < 3 ? c : 0], c < 3, prev, prev_acc, acc);
      prev = vecs[c < 3 ? c : 0];
      prev_acc = acc;
    end
    checkOutput("pre_rst_level", level, 3);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    checkOutput("mid_rst_level", level, 0);
    checkOutput("mid_rst_issue_ready", bus.issue_ready, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decoder resumes cleanly after reset.
    bus.out_ready = 1'b1;
    applyStimulus(vecs[10], 1'b1, vecs[0], 1'b0, acc);
    prev_acc = acc;
    applyStimulus(vecs[0], 1'b0, vecs[10], prev_acc, acc);
    waitDrain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
